// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: central pipeline sequencer for the 5-stage CPU.
//
// Detects load-use hazards and taken branches, and watches a multi-cycle data
// memory. From these it drives the enables, bubble and flush controls of the
// PC, IF/ID, ID/EX and EX/MEM registers. All hazard responses are same-cycle
// combinational decodes of the registered state and the current inputs.
//
// Parameters:
//   FLUSH_CYCLES  total IF/ID flush + ID/EX bubble cycles per taken branch (1..7)
//   MEM_TIMEOUT   consecutive Mem_busy cycles before Mem_timeout is raised (1..255)
//   ZERO_REG      register index that never creates a hazard (XZR)
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   Id_Rn, Id_Rm        source registers of the instruction in ID
//   Id_UsesRn/Rm        ID instruction actually reads Rn / Rm
//   Ex_Rd, Ex_RegWE     destination / write enable of the instruction in EX
//   Ex_Mem2Reg          EX instruction is a load
//   Br_taken            taken branch resolved this cycle
//   Mem_busy            data memory has not completed this cycle's access
//   PC_WE, IFID_WE, IDEX_WE, EXMEM_WE   stage register enables
//   IFID_flush          load a NOP into IF/ID
//   IDEX_bubble         load a NOP into ID/EX
//   Mem_timeout         sticky memory-timeout error flag
//
// Optional build macro HAZARD_PERF_CNT_EN adds saturating 32-bit counters
// Perf_stall_cnt, Perf_flush_cnt and Perf_memwait_cnt (load-use stall cycles,
// flush cycles and memory-busy stall cycles respectively).

module hazard_stall_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned ZERO_REG     = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Id_Rn,
    input  logic [4:0] Id_Rm,
    input  logic       Id_UsesRn,
    input  logic       Id_UsesRm,
    input  logic [4:0] Ex_Rd,
    input  logic       Ex_RegWE,
    input  logic       Ex_Mem2Reg,
    input  logic       Br_taken,
    input  logic       Mem_busy,
    output logic       PC_WE,
    output logic       IFID_WE,
    output logic       IFID_flush,
    output logic       IDEX_WE,
    output logic       IDEX_bubble,
    output logic       EXMEM_WE,
    output logic       Mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] Perf_stall_cnt,
    output logic [31:0] Perf_flush_cnt,
    output logic [31:0] Perf_memwait_cnt
`endif
);

    localparam logic [2:0] FlReload   = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TimeoutLim = 8'(MEM_TIMEOUT);
    localparam logic [4:0] ZeroReg    = 5'(ZERO_REG);
    localparam bit         MultiFlush = (FLUSH_CYCLES > 1);

    typedef enum logic [1:0] {StRun, StMemWait, StFlush} state_t;

    state_t     state_q;
    logic [7:0] wait_cnt_q;
    logic [2:0] fl_cnt_q;
    logic       timeout_q;

    logic       loaduse;
    logic [7:0] wait_inc;
    logic       stall_cyc;

    assign loaduse = Ex_RegWE & Ex_Mem2Reg & (Ex_Rd != ZeroReg) &
                     ((Id_UsesRn & (Id_Rn == Ex_Rd)) | (Id_UsesRm & (Id_Rm == Ex_Rd)));

    // Consecutive busy-cycle count, saturating at 255.
    assign wait_inc = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;

    // Output decode. MEMWAIT with the memory done decodes exactly like RUN;
    // FLUSH overrides branch/load-use because the ID content is being discarded.
    always_comb begin
        PC_WE       = 1'b1;
        IFID_WE     = 1'b1;
        IDEX_WE     = 1'b1;
        EXMEM_WE    = 1'b1;
        IFID_flush  = 1'b0;
        IDEX_bubble = 1'b0;
        stall_cyc   = 1'b0;
        if (reset) begin
            PC_WE       = 1'b0;
            IFID_WE     = 1'b0;
            IDEX_WE     = 1'b0;
            EXMEM_WE    = 1'b0;
            IFID_flush  = 1'b1;
            IDEX_bubble = 1'b1;
        end else if (Mem_busy) begin
            PC_WE    = 1'b0;
            IFID_WE  = 1'b0;
            IDEX_WE  = 1'b0;
            EXMEM_WE = 1'b0;
        end else if (state_q == StFlush || Br_taken) begin
            IFID_flush  = 1'b1;
            IDEX_bubble = 1'b1;
        end else if (loaduse) begin
            PC_WE       = 1'b0;
            IFID_WE     = 1'b0;
            IDEX_bubble = 1'b1;
            stall_cyc   = 1'b1;
        end
    end

    assign Mem_timeout = timeout_q & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StRun;
            wait_cnt_q <= 8'd0;
            fl_cnt_q   <= 3'd0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= Mem_busy ? wait_inc : 8'd0;
            if (Mem_busy && (wait_inc >= TimeoutLim)) begin
                timeout_q <= 1'b1;
            end
            case (state_q)
                StRun, StMemWait: begin
                    if (Mem_busy) begin
                        state_q <= StMemWait;
                    end else if (Br_taken && MultiFlush) begin
                        state_q  <= StFlush;
                        fl_cnt_q <= FlReload;
                    end else begin
                        state_q <= StRun;
                    end
                end
                StFlush: begin
                    // A busy memory freezes the flush sequence in place.
                    if (!Mem_busy) begin
                        if (Br_taken) begin
                            fl_cnt_q <= FlReload;
                        end else begin
                            fl_cnt_q <= fl_cnt_q - 3'd1;
                            if (fl_cnt_q <= 3'd1) begin
                                state_q <= StRun;
                            end
                        end
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            Perf_stall_cnt   <= 32'd0;
            Perf_flush_cnt   <= 32'd0;
            Perf_memwait_cnt <= 32'd0;
        end else begin
            if (stall_cyc && Perf_stall_cnt != 32'hFFFF_FFFF) begin
                Perf_stall_cnt <= Perf_stall_cnt + 32'd1;
            end
            if (IFID_flush && Perf_flush_cnt != 32'hFFFF_FFFF) begin
                Perf_flush_cnt <= Perf_flush_cnt + 32'd1;
            end
            if (Mem_busy && Perf_memwait_cnt != 32'hFFFF_FFFF) begin
                Perf_memwait_cnt <= Perf_memwait_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_stall;
    assign unused_stall = stall_cyc;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: a vector table walked from reset
// plus hand-written multi-cycle sequences (branch flush, memory wait, timeout).
// The main DUT uses FLUSH_CYCLES=3, MEM_TIMEOUT=8; a second default-parameter
// DUT shares the inputs to cover the single-cycle flush build.

module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] Id_Rn = 5'd0, Id_Rm = 5'd0, Ex_Rd = 5'd0;
    logic       Id_UsesRn = 1'b0, Id_UsesRm = 1'b0;
    logic       Ex_RegWE = 1'b0, Ex_Mem2Reg = 1'b0;
    logic       Br_taken = 1'b0, Mem_busy = 1'b0;

    logic PC_WE, IFID_WE, IFID_flush, IDEX_WE, IDEX_bubble, EXMEM_WE, Mem_timeout;
    logic d_PC_WE, d_IFID_WE, d_IFID_flush, d_IDEX_WE, d_IDEX_bubble, d_EXMEM_WE, d_Mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] p_stall, p_flush, p_mem, d_stall, d_flush, d_mem;
`endif

    int checks = 0;
    int errors = 0;

    // Output vector order: PC_WE, IFID_WE, IFID_flush, IDEX_WE, IDEX_bubble, EXMEM_WE, Mem_timeout
    localparam logic [6:0] NORM  = 7'b1101010;
    localparam logic [6:0] STALL = 7'b0001110;
    localparam logic [6:0] FLSH  = 7'b1111110;
    localparam logic [6:0] HOLD  = 7'b0000000;
    localparam logic [6:0] RST   = 7'b0010100;

    logic [6:0] got, got_d;
    assign got   = {PC_WE, IFID_WE, IFID_flush, IDEX_WE, IDEX_bubble, EXMEM_WE, Mem_timeout};
    assign got_d = {d_PC_WE, d_IFID_WE, d_IFID_flush, d_IDEX_WE, d_IDEX_bubble, d_EXMEM_WE,
                    d_Mem_timeout};

    hazard_stall_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(8), .ZERO_REG(31)) dut (
        .clk(clk), .reset(reset), .Id_Rn(Id_Rn), .Id_Rm(Id_Rm), .Id_UsesRn(Id_UsesRn),
        .Id_UsesRm(Id_UsesRm), .Ex_Rd(Ex_Rd), .Ex_RegWE(Ex_RegWE), .Ex_Mem2Reg(Ex_Mem2Reg),
        .Br_taken(Br_taken), .Mem_busy(Mem_busy), .PC_WE(PC_WE), .IFID_WE(IFID_WE),
        .IFID_flush(IFID_flush), .IDEX_WE(IDEX_WE), .IDEX_bubble(IDEX_bubble),
        .EXMEM_WE(EXMEM_WE), .Mem_timeout(Mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
        , .Perf_stall_cnt(p_stall), .Perf_flush_cnt(p_flush), .Perf_memwait_cnt(p_mem)
`endif
    );

    hazard_stall_ctrl dut_d (
        .clk(clk), .reset(reset), .Id_Rn(Id_Rn), .Id_Rm(Id_Rm), .Id_UsesRn(Id_UsesRn),
        .Id_UsesRm(Id_UsesRm), .Ex_Rd(Ex_Rd), .Ex_RegWE(Ex_RegWE), .Ex_Mem2Reg(Ex_Mem2Reg),
        .Br_taken(Br_taken), .Mem_busy(Mem_busy), .PC_WE(d_PC_WE), .IFID_WE(d_IFID_WE),
        .IFID_flush(d_IFID_flush), .IDEX_WE(d_IDEX_WE), .IDEX_bubble(d_IDEX_bubble),
        .EXMEM_WE(d_EXMEM_WE), .Mem_timeout(d_Mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
        , .Perf_stall_cnt(d_stall), .Perf_flush_cnt(d_flush), .Perf_memwait_cnt(d_mem)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       busy;
        logic       br;
        logic [4:0] ex_rd;
        logic       ex_we;
        logic       ex_m2r;
        logic [4:0] id_rn;
        logic [4:0] id_rm;
        logic       urn;
        logic       urm;
        logic [6:0] exp;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance to the next falling edge, then clear all hazard inputs.
    task automatic idle_inputs();
        @(negedge clk);
        reset = 1'b0; Mem_busy = 1'b0; Br_taken = 1'b0;
        Ex_Rd = 5'd0; Ex_RegWE = 1'b0; Ex_Mem2Reg = 1'b0;
        Id_Rn = 5'd0; Id_Rm = 5'd0; Id_UsesRn = 1'b0; Id_UsesRm = 1'b0;
    endtask

    task automatic set_loaduse();
        Ex_Rd = 5'd2; Ex_RegWE = 1'b1; Ex_Mem2Reg = 1'b1; Id_Rn = 5'd2; Id_UsesRn = 1'b1;
    endtask

    initial begin
        //                 rst   busy  br    rd     we    m2r   rn     rm     urn   urm
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, RST};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, NORM};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 5'd2,  1'b1, 1'b1, 5'd2,  5'd0,  1'b1, 1'b0, STALL};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 5'd2,  1'b0, 1'b0, 5'd2,  5'd0,  1'b1, 1'b0, NORM};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 5'd31, 1'b1, 1'b1, 5'd31, 5'd0,  1'b1, 1'b0, NORM};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 5'd2,  1'b1, 1'b1, 5'd2,  5'd0,  1'b0, 1'b0, NORM};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 5'd5,  1'b1, 1'b1, 5'd1,  5'd5,  1'b1, 1'b1, STALL};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 5'd2,  1'b1, 1'b0, 5'd2,  5'd0,  1'b1, 1'b0, NORM};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 5'd2,  1'b0, 1'b1, 5'd2,  5'd0,  1'b1, 1'b0, NORM};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 5'd3,  1'b1, 1'b1, 5'd2,  5'd3,  1'b1, 1'b0, NORM};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 5'd2,  1'b1, 1'b1, 5'd2,  5'd0,  1'b1, 1'b0, HOLD};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 5'd2,  1'b1, 1'b1, 5'd2,  5'd0,  1'b1, 1'b0, STALL};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 5'd2,  1'b1, 1'b1, 5'd2,  5'd0,  1'b1, 1'b0, FLSH};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 5'd2,  1'b1, 1'b1, 5'd2,  5'd0,  1'b1, 1'b0, FLSH};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, HOLD};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, FLSH};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, NORM};

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset = vecs[i].rst; Mem_busy = vecs[i].busy; Br_taken = vecs[i].br;
            Ex_Rd = vecs[i].ex_rd; Ex_RegWE = vecs[i].ex_we; Ex_Mem2Reg = vecs[i].ex_m2r;
            Id_Rn = vecs[i].id_rn; Id_Rm = vecs[i].id_rm;
            Id_UsesRn = vecs[i].urn; Id_UsesRm = vecs[i].urm;
            #1 check($sformatf("vec%0d", i), got, vecs[i].exp);
        end

        // Single branch pulse: 3 flush cycles in the main DUT, 1 in the default DUT.
        idle_inputs(); Br_taken = 1'b1;
        #1 check("br_c1", got, FLSH); check("br_c1_def", got_d, FLSH);
        idle_inputs(); #1 check("br_c2", got, FLSH); check("br_c2_def", got_d, NORM);
        idle_inputs(); #1 check("br_c3", got, FLSH);
        idle_inputs(); #1 check("br_c4", got, NORM);

        // Memory busy for 4 cycles with a branch held throughout.
        for (int i = 0; i < 4; i++) begin
            idle_inputs(); Mem_busy = 1'b1; Br_taken = 1'b1;
            #1 check($sformatf("mbr_busy%0d", i), got, HOLD);
        end
        idle_inputs(); Br_taken = 1'b1; #1 check("mbr_exit", got, FLSH);
        idle_inputs(); #1 check("mbr_fl2", got, FLSH);
        idle_inputs(); #1 check("mbr_fl3", got, FLSH);
        idle_inputs(); #1 check("mbr_run", got, NORM);

        // Reset mid-flush abandons the flush.
        idle_inputs(); Br_taken = 1'b1; #1 check("rf_br", got, FLSH);
        idle_inputs(); reset = 1'b1; #1 check("rf_rst", got, RST);
        idle_inputs(); #1 check("rf_after", got, NORM);

        // Timeout: 10 busy cycles, flag visible from the 9th cycle onwards.
        for (int i = 1; i <= 10; i++) begin
            idle_inputs(); Mem_busy = 1'b1;
            #1 check($sformatf("to_busy%0d", i), got, (i >= 9) ? 7'b0000001 : HOLD);
        end
        idle_inputs(); #1 check("to_sticky", got, 7'b1101011);
        check("to_def_clear", got_d, NORM);
        idle_inputs(); reset = 1'b1; #1 check("to_rst", got, RST);
        idle_inputs(); #1 check("to_cleared", got, NORM);

`ifdef HAZARD_PERF_CNT_EN
        idle_inputs(); reset = 1'b1;
        idle_inputs(); set_loaduse();
        idle_inputs();
        idle_inputs(); set_loaduse();
        idle_inputs();
        idle_inputs(); Br_taken = 1'b1;
        idle_inputs(); idle_inputs(); idle_inputs(); idle_inputs();
        #1 check32("perf_stall", p_stall, 32'd2);
        check32("perf_flush", p_flush, 32'd3);
        check32("perf_mem", p_mem, 32'd0);
        check32("perf_flush_def", d_flush, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
